// File: rtl/serial_frame_rx.sv
// Serial frame receiver: recovers start/data/stop frames from a 1-bit line
// that is already in the clk domain and presents DATA_W-bit parallel words.
module serial_frame_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sd_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    // Next-state and registered-output logic; cnt wraps at every sample point.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!sd_in) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (sd_in) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sd_in;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (sd_in) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // A held-low line after a bad stop bit must not look like a new start.
            S_BREAK: begin
                if (sd_in) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: directed frames on a 4-clk/bit and a
// 5-clk/bit instance; a monitor checks every output pulse against a queue.
module tb_serial_frame_rx;

    typedef struct {
        bit         kind;   // 0 = data_valid, 1 = frame_err
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sd = 1'b1;
    logic       sd5 = 1'b1;
    logic [7:0] dout4, dout5;
    logic       dv4, fe4, bz4, dv5, fe5, bz5;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q4[$];
    exp_t q5[$];

    serial_frame_rx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset(reset), .sd_in(sd),
        .data_out(dout4), .data_valid(dv4), .frame_err(fe4), .busy(bz4)
    );

    serial_frame_rx #(.DATA_W(8), .CLKS_PER_BIT(5)) dut5 (
        .clk(clk), .reset(reset), .sd_in(sd5),
        .data_out(dout5), .data_valid(dv5), .frame_err(fe5), .busy(bz5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_pulse(input string tag, input logic dv, input logic fe,
                             input logic [7:0] dout, inout exp_t q[$]);
        exp_t e;
        check({tag, " valid_and_err_exclusive"}, int'(dv & fe), 0);
        if (q.size() == 0) begin
            check({tag, " unexpected_pulse"}, int'({dv, fe}), 0);
        end else begin
            e = q.pop_front();
            check({tag, " pulse_kind"}, int'(fe), int'(e.kind));
            check({tag, " pulse_cycle"}, cyc, e.cyc);
            if (!e.kind) check({tag, " data_out"}, int'(dout), int'(e.data));
        end
    endtask

    // Monitor: every output pulse is matched against the head of its scoreboard.
    always @(negedge clk) begin
        if (dv4 || fe4) chk_pulse("cpb4", dv4, fe4, dout4, q4);
        if (dv5 || fe5) chk_pulse("cpb5", dv5, fe5, dout5, q5);
    end

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) sd5 = v;
        else     sd  = v;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the start edge E0 is the next posedge.
    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stopb,
                              input int extra_low);
        int   cpb;
        int   e0;
        exp_t e;
        cpb    = sel ? 5 : 4;
        e0     = cyc + 1;
        e.kind = ~stopb;
        e.data = b;
        e.cyc  = e0 + cpb / 2 + 9 * cpb;
        if (sel) q5.push_back(e);
        else     q4.push_back(e);
        drive(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive(sel, b[i], cpb);
        drive(sel, stopb, cpb);
        if (extra_low > 0) drive(sel, 1'b0, extra_low);
    endtask

    initial begin
        int e0;
        repeat (3) @(negedge clk);
        check("reset data_out", int'(dout4), 0);
        check("reset data_valid", int'(dv4), 0);
        check("reset frame_err", int'(fe4), 0);
        check("reset busy", int'(bz4), 0);
        reset = 1'b0;
        drive(1'b0, 1'b1, 3);

        // Test 1: good 0xA5 frame
        send_frame(1'b0, 8'hA5, 1'b1, 0);
        drive(1'b0, 1'b1, 2);
        check("t1 data_out hold", int'(dout4), 8'hA5);
        check("t1 idle busy", int'(bz4), 0);

        // Test 2: one-clock glitch
        e0 = cyc + 1;
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 1);
        check("t2 busy after E0", int'(bz4), 1);
        @(negedge clk);
        check("t2 cycle E0+2", cyc, e0 + 2);
        check("t2 busy cleared", int'(bz4), 0);
        drive(1'b0, 1'b1, 60);
        check("t2 data_out unchanged", int'(dout4), 8'hA5);

        // Test 3: good 0x3C, then 0x77 with a low stop held 8 extra clocks
        send_frame(1'b0, 8'h3C, 1'b1, 0);
        drive(1'b0, 1'b1, 4);
        send_frame(1'b0, 8'h77, 1'b0, 8);
        check("t3 break busy", int'(bz4), 1);
        check("t3 data_out after err", int'(dout4), 8'h3C);
        drive(1'b0, 1'b1, 2);
        check("t3 idle after break", int'(bz4), 0);
        drive(1'b0, 1'b1, 50);
        check("t3 data_out still", int'(dout4), 8'h3C);

        // Test 4: reset at E0+15 in the middle of an 0xFF frame
        drive(1'b0, 1'b0, 4);
        drive(1'b0, 1'b1, 11);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4 reset data_out", int'(dout4), 0);
        check("t4 reset data_valid", int'(dv4), 0);
        check("t4 reset frame_err", int'(fe4), 0);
        check("t4 reset busy", int'(bz4), 0);
        drive(1'b0, 1'b1, 40);
        send_frame(1'b0, 8'h5A, 1'b1, 0);
        drive(1'b0, 1'b1, 4);
        check("t4 data_out 5A", int'(dout4), 8'h5A);

        // Test 5: back-to-back 0x00 and 0xFF
        send_frame(1'b0, 8'h00, 1'b1, 0);
        send_frame(1'b0, 8'hFF, 1'b1, 0);
        drive(1'b0, 1'b1, 4);
        check("t5 data_out FF", int'(dout4), 8'hFF);

        // Test 6: 0xA5 at five clocks per bit
        check("t6 reset data_out", int'(dout5), 0);
        send_frame(1'b1, 8'hA5, 1'b1, 0);
        drive(1'b1, 1'b1, 4);
        check("t6 data_out A5", int'(dout5), 8'hA5);
        check("t6 idle busy", int'(bz5), 0);

        repeat (20) @(negedge clk);
        check("scoreboard cpb4 drained", q4.size(), 0);
        check("scoreboard cpb5 drained", q5.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
